// File: rtl/dispatch_stage.sv
// dispatch_stage: RV32I decode/dispatch between the fetcher and ROB/RS/LSB.
// Operands resolve from x0, the previous dispatch, the register file and the CDB into one registered bundle.
module dispatch_stage #(
   parameter int ROB_W = 5,
   parameter int N_CDB = 2
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic                   flush_in,
   input  logic                   if_valid,
   input  logic                   if_pred_taken,
   input  logic [31:0]            if_inst,
   input  logic [31:0]            if_pc,
   output logic                   if_ready,
   output logic                   redirect_valid,
   output logic [31:0]            redirect_pc,
   output logic [4:0]             rf_rs1,
   output logic [4:0]             rf_rs2,
   input  logic [31:0]            rf_val1,
   input  logic [31:0]            rf_val2,
   input  logic                   rf_busy1,
   input  logic                   rf_busy2,
   input  logic [ROB_W-1:0]       rf_tag1,
   input  logic [ROB_W-1:0]       rf_tag2,
   input  logic [N_CDB-1:0]       cdb_valid,
   input  logic [N_CDB*ROB_W-1:0] cdb_tag,
   input  logic [N_CDB*32-1:0]    cdb_val,
   input  logic                   rob_full,
   input  logic                   rs_full,
   input  logic                   lsb_full,
   output logic                   d_rob_valid,
   output logic                   d_rs_valid,
   output logic                   d_lsb_valid,
   output logic [6:0]             d_opcode,
   output logic [2:0]             d_funct3,
   output logic                   d_f7b5,
   output logic [4:0]             d_rd,
   output logic [ROB_W-1:0]       d_tag,
   output logic [31:0]            d_pc,
   output logic [31:0]            d_imm,
   output logic [31:0]            d_v1,
   output logic [31:0]            d_v2,
   output logic                   d_busy1,
   output logic                   d_busy2,
   output logic [ROB_W-1:0]       d_q1,
   output logic [ROB_W-1:0]       d_q2,
   output logic                   d_pred_taken,
   output logic                   d_rob_ready,
   output logic [31:0]            d_rob_value
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_L     = 7'b0000011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   typedef struct packed {
      logic             busy;
      logic [ROB_W-1:0] tag;
      logic [31:0]      val;
   } opnd_t;

   logic [6:0]       opcode_s;
   logic [2:0]       funct3_s;
   logic [4:0]       rs1_s;
   logic [4:0]       rs2_s;
   logic [31:0]      imm_i_s;
   logic [31:0]      imm_st_s;
   logic [31:0]      imm_b_s;
   logic [31:0]      imm_u_s;
   logic [31:0]      imm_j_s;
   logic [31:0]      shamt_s;
   logic             shift_s;
   logic             need_rob_s;
   logic             need_rs_s;
   logic             need_lsb_s;
   logic             use1_s;
   logic             use2_s;
   logic             is_jal_s;
   logic             is_jalr_s;
   logic             f7b5_s;
   logic [4:0]       rd_s;
   logic [31:0]      imm_s;
   logic             rob_ready_s;
   logic [31:0]      rob_value_s;
   logic             fwd1_s;
   logic             fwd2_s;
   opnd_t            op1_s;
   opnd_t            op2_s;
   logic [31:0]      jal_target_s;
   logic [31:0]      jalr_target_s;
   logic             stall_s;
   logic             accept_s;
   logic [ROB_W-1:0] next_tag_r;

   assign opcode_s = if_inst[6:0];
   assign funct3_s = if_inst[14:12];
   assign rs1_s    = if_inst[19:15];
   assign rs2_s    = if_inst[24:20];
   assign rf_rs1   = rs1_s;
   assign rf_rs2   = rs2_s;

   assign imm_i_s  = {{20{if_inst[31]}}, if_inst[31:20]};
   assign imm_st_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
   assign imm_b_s  = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
   assign imm_u_s  = {if_inst[31:12], 12'd0};
   assign imm_j_s  = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
   assign shamt_s  = {27'd0, if_inst[24:20]};
   assign shift_s  = (funct3_s == 3'b001) || (funct3_s == 3'b101);

   // First match wins: x0, previous dispatch, register file; then CDB capture clears busy (lowest port wins).
   function automatic opnd_t resolve(input logic used, input logic [4:0] src, input logic fwd,
                                     input logic busy, input logic [ROB_W-1:0] tag, input logic [31:0] val,
                                     input logic [N_CDB-1:0] cv, input logic [N_CDB*ROB_W-1:0] ct,
                                     input logic [N_CDB*32-1:0] cd);
      opnd_t       r;
      logic        hit;
      logic [31:0] cap;
      r   = '0;
      hit = 1'b0;
      cap = 32'd0;
      if (!used || (src == 5'd0)) begin
         r = '0;
      end else if (fwd) begin
         r.busy = 1'b1;
         r.tag  = d_tag;
         r.val  = 32'd0;
      end else begin
         r.busy = busy;
         r.tag  = tag;
         r.val  = val;
      end
      for (int i = 0; i < N_CDB; i++) begin
         if (r.busy && !hit && cv[i] && (ct[i*ROB_W +: ROB_W] == r.tag)) begin
            hit = 1'b1;
            cap = cd[i*32 +: 32];
         end else begin
            hit = hit;
         end
      end
      if (hit) begin
         r.busy = 1'b0;
         r.val  = cap;
      end else if (r.busy) begin
         r.val = 32'd0;
      end else begin
         r.val = r.val;
      end
      return r;
   endfunction

   // Opcode classification, immediate selection and known-at-dispatch ROB results.
   always_comb begin
      need_rob_s  = 1'b0;
      need_rs_s   = 1'b0;
      need_lsb_s  = 1'b0;
      use1_s      = 1'b0;
      use2_s      = 1'b0;
      is_jal_s    = 1'b0;
      is_jalr_s   = 1'b0;
      f7b5_s      = 1'b0;
      rd_s        = if_inst[11:7];
      imm_s       = 32'd0;
      rob_ready_s = 1'b0;
      rob_value_s = 32'd0;
      case (opcode_s)
         OP_R: begin
            need_rob_s = 1'b1;
            need_rs_s  = 1'b1;
            use1_s     = 1'b1;
            use2_s     = 1'b1;
            f7b5_s     = if_inst[30];
         end
         OP_I: begin
            need_rob_s = 1'b1;
            need_rs_s  = 1'b1;
            use1_s     = 1'b1;
            if (shift_s) begin
               imm_s  = shamt_s;
               f7b5_s = if_inst[30];
            end else begin
               imm_s  = imm_i_s;
            end
         end
         OP_B: begin
            need_rob_s = 1'b1;
            need_rs_s  = 1'b1;
            use1_s     = 1'b1;
            use2_s     = 1'b1;
            rd_s       = 5'd0;
            imm_s      = imm_b_s;
         end
         OP_L: begin
            need_rob_s = 1'b1;
            need_lsb_s = 1'b1;
            use1_s     = 1'b1;
            imm_s      = imm_i_s;
         end
         OP_S: begin
            need_rob_s = 1'b1;
            need_lsb_s = 1'b1;
            use1_s     = 1'b1;
            use2_s     = 1'b1;
            rd_s       = 5'd0;
            imm_s      = imm_st_s;
         end
         OP_LUI: begin
            need_rob_s  = 1'b1;
            imm_s       = imm_u_s;
            rob_ready_s = 1'b1;
            rob_value_s = imm_u_s;
         end
         OP_AUIPC: begin
            need_rob_s  = 1'b1;
            imm_s       = imm_u_s;
            rob_ready_s = 1'b1;
            rob_value_s = if_pc + imm_u_s;
         end
         OP_JAL: begin
            need_rob_s  = 1'b1;
            is_jal_s    = 1'b1;
            imm_s       = imm_j_s;
            rob_ready_s = 1'b1;
            rob_value_s = if_pc + 32'd4;
         end
         OP_JALR: begin
            need_rob_s  = 1'b1;
            is_jalr_s   = 1'b1;
            use1_s      = 1'b1;
            imm_s       = imm_i_s;
            rob_ready_s = 1'b1;
            rob_value_s = if_pc + 32'd4;
         end
         default: begin
            rd_s = if_inst[11:7];
         end
      endcase
   end

   // The rename table lags one cycle, so the bundle still in the output register must be forwarded.
   assign fwd1_s = d_rob_valid && (d_rd != 5'd0) && (d_rd == rs1_s);
   assign fwd2_s = d_rob_valid && (d_rd != 5'd0) && (d_rd == rs2_s);
   assign op1_s  = resolve(use1_s, rs1_s, fwd1_s, rf_busy1, rf_tag1, rf_val1, cdb_valid, cdb_tag, cdb_val);
   assign op2_s  = resolve(use2_s, rs2_s, fwd2_s, rf_busy2, rf_tag2, rf_val2, cdb_valid, cdb_tag, cdb_val);

   assign jal_target_s  = if_pc + imm_j_s;
   assign jalr_target_s = (op1_s.val + imm_i_s) & 32'hFFFF_FFFE;

   assign stall_s  = rob_full || (need_rs_s && rs_full) || (need_lsb_s && lsb_full) || (is_jalr_s && op1_s.busy);
   assign if_ready = !rst_in && rdy_in && !flush_in && !stall_s;
   assign accept_s = if_valid && if_ready;

   // Dispatch bundle, redirect pulse and tag counter; rdy_in low freezes everything.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         next_tag_r     <= '0;
         d_rob_valid    <= 1'b0;
         d_rs_valid     <= 1'b0;
         d_lsb_valid    <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= 32'd0;
         d_opcode       <= 7'd0;
         d_funct3       <= 3'd0;
         d_f7b5         <= 1'b0;
         d_rd           <= 5'd0;
         d_tag          <= '0;
         d_pc           <= 32'd0;
         d_imm          <= 32'd0;
         d_v1           <= 32'd0;
         d_v2           <= 32'd0;
         d_busy1        <= 1'b0;
         d_busy2        <= 1'b0;
         d_q1           <= '0;
         d_q2           <= '0;
         d_pred_taken   <= 1'b0;
         d_rob_ready    <= 1'b0;
         d_rob_value    <= 32'd0;
      end else if (!rdy_in) begin
         next_tag_r <= next_tag_r;
      end else if (flush_in) begin
         next_tag_r     <= '0;
         d_rob_valid    <= 1'b0;
         d_rs_valid     <= 1'b0;
         d_lsb_valid    <= 1'b0;
         redirect_valid <= 1'b0;
      end else if (accept_s) begin
         if (need_rob_s) begin
            next_tag_r <= next_tag_r + {{(ROB_W-1){1'b0}}, 1'b1};
         end else begin
            next_tag_r <= next_tag_r;
         end
         d_rob_valid    <= need_rob_s;
         d_rs_valid     <= need_rs_s;
         d_lsb_valid    <= need_lsb_s;
         redirect_valid <= is_jal_s || is_jalr_s;
         redirect_pc    <= is_jalr_s ? jalr_target_s : (is_jal_s ? jal_target_s : redirect_pc);
         d_opcode       <= opcode_s;
         d_funct3       <= funct3_s;
         d_f7b5         <= f7b5_s;
         d_rd           <= rd_s;
         d_tag          <= next_tag_r;
         d_pc           <= if_pc;
         d_imm          <= imm_s;
         d_v1           <= op1_s.val;
         d_v2           <= op2_s.val;
         d_busy1        <= op1_s.busy;
         d_busy2        <= op2_s.busy;
         d_q1           <= op1_s.tag;
         d_q2           <= op2_s.tag;
         d_pred_taken   <= if_pred_taken;
         d_rob_ready    <= rob_ready_s;
         d_rob_value    <= rob_value_s;
      end else begin
         d_rob_valid    <= 1'b0;
         d_rs_valid     <= 1'b0;
         d_lsb_valid    <= 1'b0;
         redirect_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage: directed scoreboard bench for dispatch_stage (ROB_W=3 so the tag wrap is reached quickly).
module tb_dispatch_stage;
   localparam int ROB_W = 3;
   localparam int N_CDB = 2;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic rst_in, rdy_in, flush_in, if_valid, if_pred_taken, if_ready;
   logic [31:0] if_inst, if_pc, redirect_pc, rf_val1, rf_val2;
   logic redirect_valid, rf_busy1, rf_busy2, rob_full, rs_full, lsb_full;
   logic [4:0] rf_rs1, rf_rs2, d_rd;
   logic [ROB_W-1:0] rf_tag1, rf_tag2, d_tag, d_q1, d_q2;
   logic [N_CDB-1:0] cdb_valid;
   logic [N_CDB*ROB_W-1:0] cdb_tag;
   logic [N_CDB*32-1:0] cdb_val;
   logic d_rob_valid, d_rs_valid, d_lsb_valid, d_f7b5, d_busy1, d_busy2, d_pred_taken, d_rob_ready;
   logic [6:0] d_opcode;
   logic [2:0] d_funct3;
   logic [31:0] d_pc, d_imm, d_v1, d_v2, d_rob_value;

   dispatch_stage #(.ROB_W(ROB_W), .N_CDB(N_CDB)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
      .if_valid(if_valid), .if_pred_taken(if_pred_taken), .if_inst(if_inst), .if_pc(if_pc),
      .if_ready(if_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_val1(rf_val1), .rf_val2(rf_val2),
      .rf_busy1(rf_busy1), .rf_busy2(rf_busy2), .rf_tag1(rf_tag1), .rf_tag2(rf_tag2),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
      .d_rob_valid(d_rob_valid), .d_rs_valid(d_rs_valid), .d_lsb_valid(d_lsb_valid),
      .d_opcode(d_opcode), .d_funct3(d_funct3), .d_f7b5(d_f7b5), .d_rd(d_rd), .d_tag(d_tag),
      .d_pc(d_pc), .d_imm(d_imm), .d_v1(d_v1), .d_v2(d_v2), .d_busy1(d_busy1), .d_busy2(d_busy2),
      .d_q1(d_q1), .d_q2(d_q2), .d_pred_taken(d_pred_taken), .d_rob_ready(d_rob_ready),
      .d_rob_value(d_rob_value)
   );

   typedef struct packed {
      logic rob, rs, lsb, redir, rr, pt, f7, b1, b2;
      logic [2:0] tag, q1, q2;
      logic [4:0] rd;
      logic [31:0] imm, v1, v2, rpc, rv;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int miscompares = 0;

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   function automatic exp_t base(input logic [2:0] tag, input logic [4:0] rd, input logic [31:0] imm);
      exp_t e;
      e = '0;
      e.tag = tag;
      e.rd  = rd;
      e.imm = imm;
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", name, obs, expv);
      end
   endtask

   task automatic clr();
      rf_val1 = 32'd0; rf_val2 = 32'd0; rf_busy1 = 1'b0; rf_busy2 = 1'b0;
      rf_tag1 = 3'd0; rf_tag2 = 3'd0; cdb_valid = 2'b00; cdb_tag = 6'd0; cdb_val = 64'd0;
   endtask

   task automatic check_out();
      exp_t e;
      logic got;
      got = d_rob_valid | d_rs_valid | d_lsb_valid | redirect_valid;
      chk("dispatch_present", 64'(got), 64'(q.size() != 0));
      if (got && q.size() != 0) begin
         e = q.pop_front();
         chk("strobes", 64'({d_rob_valid, d_rs_valid, d_lsb_valid, redirect_valid}), 64'({e.rob, e.rs, e.lsb, e.redir}));
         chk("tag", 64'(d_tag), 64'(e.tag));
         chk("op1", {31'd0, d_busy1, e.b1 ? 32'(d_q1) : d_v1}, {31'd0, e.b1, e.b1 ? 32'(e.q1) : e.v1});
         chk("op2", {31'd0, d_busy2, e.b2 ? 32'(d_q2) : d_v2}, {31'd0, e.b2, e.b2 ? 32'(e.q2) : e.v2});
         chk("imm_rd_f7", {26'd0, d_f7b5, d_rd, d_imm}, {26'd0, e.f7, e.rd, e.imm});
         chk("rob_result", {30'd0, d_pred_taken, d_rob_ready, d_rob_value}, {30'd0, e.pt, e.rr, e.rv});
         if (e.redir) chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
      end else if (q.size() != 0) begin
         void'(q.pop_front());
      end
   endtask

   // Called at a negedge with inputs already driven; checks if_ready, then one clock, then the output.
   task automatic apply(input logic exp_rdy, input logic push, input exp_t e);
      #1;
      chk("if_ready", 64'(if_ready), 64'(exp_rdy));
      if (push) q.push_back(e);
      @(posedge clk_in);
      #1;
      check_out();
      @(negedge clk_in);
   endtask

   initial begin
      exp_t e, prev;
      rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; if_pred_taken = 1'b0;
      rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
      if_valid = 1'b1; if_pc = 32'd0; if_inst = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3);
      clr();
      @(negedge clk_in);
      #1 chk("reset_if_ready", 64'(if_ready), 64'd0);
      @(negedge clk_in);
      rst_in = 1'b0;
      chk("reset_strobes_tag", 64'({d_rob_valid, d_rs_valid, d_lsb_valid, redirect_valid, d_tag}), 64'd0);
      chk("reset_pc_imm", {redirect_pc, d_imm}, 64'd0);

      // add x3,x1,x2
      if_pc = 32'h100; if_inst = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd3);
      rf_val1 = 32'd5; rf_val2 = 32'd7;
      #1 chk("rf_rs_addr", 64'({rf_rs1, rf_rs2}), 64'({5'd1, 5'd2}));
      e = base(3'd0, 5'd3, 32'd0); e.rob = 1'b1; e.rs = 1'b1; e.v1 = 32'd5; e.v2 = 32'd7;
      apply(1'b1, 1'b1, e);

      // addi x5,x0,1 : x0 ignores the rf, rs2 unused
      if_pc = 32'h104; if_inst = enc_i(12'd1, 5'd0, 3'd0, 5'd5, 7'b0010011);
      rf_busy1 = 1'b1; rf_tag1 = 3'd2; rf_val1 = 32'd99; rf_val2 = 32'd55;
      e = base(3'd1, 5'd5, 32'd1); e.rob = 1'b1; e.rs = 1'b1;
      apply(1'b1, 1'b1, e);

      // add x6,x5,x5 back to back : forwarded from tag 1
      clr(); if_pc = 32'h108; if_inst = enc_r(7'd0, 5'd5, 5'd5, 3'd0, 5'd6);
      rf_val1 = 32'd123; rf_val2 = 32'd123;
      e = base(3'd2, 5'd6, 32'd0); e.rob = 1'b1; e.rs = 1'b1;
      e.b1 = 1'b1; e.q1 = 3'd1; e.b2 = 1'b1; e.q2 = 3'd1;
      apply(1'b1, 1'b1, e);

      // sub x7,x8,x9 : rs1 captured from cdb port 1, rs2 stays pending
      clr(); if_pc = 32'h10C; if_inst = enc_r(7'b0100000, 5'd9, 5'd8, 3'd0, 5'd7);
      rf_busy1 = 1'b1; rf_tag1 = 3'd5; rf_busy2 = 1'b1; rf_tag2 = 3'd6;
      cdb_valid = 2'b11; cdb_tag = {3'd5, 3'd2}; cdb_val = {32'h0000_DEAD, 32'h0000_1111};
      e = base(3'd3, 5'd7, 32'd0); e.rob = 1'b1; e.rs = 1'b1; e.v1 = 32'h0000_DEAD;
      e.b2 = 1'b1; e.q2 = 3'd6; e.f7 = 1'b1;
      apply(1'b1, 1'b1, e);

      // sw x10,-8(x11) : both cdb ports match, port 0 wins
      clr(); if_pc = 32'h110; if_inst = enc_s(12'hFF8, 5'd10, 5'd11, 3'b010);
      rf_busy1 = 1'b1; rf_tag1 = 3'd4; rf_val2 = 32'h77;
      cdb_valid = 2'b11; cdb_tag = {3'd4, 3'd4}; cdb_val = {32'h0000_BBBB, 32'h0000_AAAA};
      e = base(3'd4, 5'd0, 32'hFFFF_FFF8); e.rob = 1'b1; e.lsb = 1'b1; e.v1 = 32'h0000_AAAA; e.v2 = 32'h77;
      apply(1'b1, 1'b1, e);

      // jalr x1,8(x2) : stalls until tag 4 broadcasts 0x200
      clr(); if_pc = 32'h200; if_inst = enc_i(12'd8, 5'd2, 3'd0, 5'd1, 7'b1100111);
      rf_busy1 = 1'b1; rf_tag1 = 3'd4; rf_val2 = 32'h55;
      apply(1'b0, 1'b0, e);
      apply(1'b0, 1'b0, e);
      cdb_valid = 2'b01; cdb_tag = {3'd0, 3'd4}; cdb_val = {32'd0, 32'h200};
      e = base(3'd5, 5'd1, 32'd8); e.rob = 1'b1; e.v1 = 32'h200;
      e.redir = 1'b1; e.rpc = 32'h208; e.rr = 1'b1; e.rv = 32'h204;
      apply(1'b1, 1'b1, e);

      // jal x1,-32 predicted taken
      clr(); rf_val1 = 32'h99; if_pred_taken = 1'b1;
      if_pc = 32'h300; if_inst = enc_j(21'h1FFFE0, 5'd1);
      e = base(3'd6, 5'd1, 32'hFFFF_FFE0); e.rob = 1'b1; e.redir = 1'b1; e.rpc = 32'h2E0;
      e.rr = 1'b1; e.rv = 32'h304; e.pt = 1'b1;
      apply(1'b1, 1'b1, e);
      if_pred_taken = 1'b0; clr();

      // lui x4,0x12345 then auipc x5,1 (tag wraps 7 -> 0)
      if_pc = 32'h400; if_inst = {20'h12345, 5'd4, 7'b0110111};
      e = base(3'd7, 5'd4, 32'h1234_5000); e.rob = 1'b1; e.rr = 1'b1; e.rv = 32'h1234_5000;
      apply(1'b1, 1'b1, e);
      if_pc = 32'h404; if_inst = {20'h00001, 5'd5, 7'b0010111};
      e = base(3'd0, 5'd5, 32'h1000); e.rob = 1'b1; e.rr = 1'b1; e.rv = 32'h1404;
      apply(1'b1, 1'b1, e);

      // unknown opcode: consumed, no strobe, no tag
      if_pc = 32'h408; if_inst = 32'h0000_000F;
      apply(1'b1, 1'b0, e);

      // beq x1,x2,-4
      if_pc = 32'h500; if_inst = enc_b(13'h1FFC, 5'd2, 5'd1, 3'd0);
      rf_val1 = 32'd1; rf_val2 = 32'd2;
      e = base(3'd1, 5'd0, 32'hFFFF_FFFC); e.rob = 1'b1; e.rs = 1'b1; e.v1 = 32'd1; e.v2 = 32'd2;
      apply(1'b1, 1'b1, e);

      // srai x9,x10,3
      if_pc = 32'h504; if_inst = enc_i({7'b0100000, 5'd3}, 5'd10, 3'b101, 5'd9, 7'b0010011);
      rf_val1 = 32'h80; rf_val2 = 32'h44;
      e = base(3'd2, 5'd9, 32'd3); e.rob = 1'b1; e.rs = 1'b1; e.v1 = 32'h80; e.f7 = 1'b1;
      apply(1'b1, 1'b1, e);

      // lsb_full blocks a load but not an add
      lsb_full = 1'b1; rf_val1 = 32'd1; rf_val2 = 32'd2;
      if_pc = 32'h508; if_inst = enc_i(12'd4, 5'd13, 3'b010, 5'd12, 7'b0000011);
      apply(1'b0, 1'b0, e);
      if_pc = 32'h50C; if_inst = enc_r(7'd0, 5'd2, 5'd1, 3'd0, 5'd14);
      e = base(3'd3, 5'd14, 32'd0); e.rob = 1'b1; e.rs = 1'b1; e.v1 = 32'd1; e.v2 = 32'd2;
      apply(1'b1, 1'b1, e);
      lsb_full = 1'b0; rf_val1 = 32'h1000;
      if_pc = 32'h508; if_inst = enc_i(12'd4, 5'd13, 3'b010, 5'd12, 7'b0000011);
      e = base(3'd4, 5'd12, 32'd4); e.rob = 1'b1; e.lsb = 1'b1; e.v1 = 32'h1000;
      apply(1'b1, 1'b1, e);

      // rob_full blocks everything
      rob_full = 1'b1; if_inst = {20'h00001, 5'd4, 7'b0110111};
      apply(1'b0, 1'b0, e);
      rob_full = 1'b0;

      // flush during a JALR stall: abandoned, tags restart at 0
      clr(); if_pc = 32'h600; if_inst = enc_i(12'd0, 5'd2, 3'd0, 5'd1, 7'b1100111);
      rf_busy1 = 1'b1; rf_tag1 = 3'd7;
      apply(1'b0, 1'b0, e);
      flush_in = 1'b1;
      apply(1'b0, 1'b0, e);
      flush_in = 1'b0; clr();
      if_pc = 32'h604; if_inst = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'b0010011);
      e = base(3'd0, 5'd1, 32'd5); e.rob = 1'b1; e.rs = 1'b1;
      apply(1'b1, 1'b1, e);
      prev = e;

      // rdy_in low holds the bundle and the tag counter
      rdy_in = 1'b0;
      if_pc = 32'h608; if_inst = enc_i(12'd6, 5'd0, 3'd0, 5'd2, 7'b0010011);
      apply(1'b0, 1'b1, prev);
      rdy_in = 1'b1;
      e = base(3'd1, 5'd2, 32'd6); e.rob = 1'b1; e.rs = 1'b1;
      apply(1'b1, 1'b1, e);

      if_valid = 1'b0;
      apply(1'b1, 1'b0, e);
      chk("queue_drained", 64'(q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
